// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the memory arbiter: FSM state encoding, default
// line/latency parameters and a small state-decode helper.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Default cache-line length (words) and memory read latency (cycles).
  localparam int LINE_WORDS_DEF = 8;
  localparam int MEM_LAT_DEF    = 4;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FILL_I = 2'd1;
  localparam logic [1:0] ST_FILL_D = 2'd2;
  localparam logic [1:0] ST_WRITE  = 2'd3;

  // True for either line-fill state.
  function automatic logic is_fill(input logic [1:0] st);
    return (st == ST_FILL_I) || (st == ST_FILL_D);
  endfunction

endpackage

// File: rtl/mem_arb_counter.sv
// -----------------------------------------------------------------------------
// mem_arb_counter
// Loadable, clearable up-counter with enable. Priority: clr > load > en.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears count)
//   clr       - synchronous clear to zero
//   load      - synchronous load of load_val
//   load_val  - value loaded when load is high
//   en        - increment by one (wraps at 2**WIDTH)
//   cnt       - current count
// -----------------------------------------------------------------------------
module mem_arb_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single memory port between an instruction-side line-fill
// requester and a data-side requester (line fill or single-word write).
// The data side always wins simultaneous requests. A fill issues LINE_WORDS
// consecutive reads starting at the line base and forwards the returned words
// with their index; the last returned word pulses the owner's done strobe.
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   i_req, i_addr          - instruction-side fill request and byte address
//   d_req, d_wr, d_addr,
//   d_wdata                - data-side request (d_wr=1 write, 0 fill)
//   i_grant, d_grant       - requester currently owns memory
//   fill_valid, fill_data,
//   fill_idx               - returned line word and its index in the line
//   i_done, d_done         - one-cycle completion pulses
//   mem_en, mem_wr,
//   mem_addr, mem_wdata    - memory request side
//   mem_rdata, mem_rvalid  - memory read return
//   busy                   - FSM is not idle
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 16,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req,
  input  logic [AWIDTH-1:0]             i_addr,
  input  logic                          d_req,
  input  logic                          d_wr,
  input  logic [AWIDTH-1:0]             d_addr,
  input  logic [DWIDTH-1:0]             d_wdata,
  output logic                          i_grant,
  output logic                          d_grant,
  output logic                          fill_valid,
  output logic [DWIDTH-1:0]             fill_data,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic                          i_done,
  output logic                          d_done,
  output logic                          mem_en,
  output logic                          mem_wr,
  output logic [AWIDTH-1:0]             mem_addr,
  output logic [DWIDTH-1:0]             mem_wdata,
  input  logic [DWIDTH-1:0]             mem_rdata,
  input  logic                          mem_rvalid,
  output logic                          busy
);

  localparam int IDXW = $clog2(LINE_WORDS);
  // Issue counter needs one extra bit so it can sit at LINE_WORDS once all
  // reads have been issued while the fill waits for the returns.
  localparam int IW = IDXW + 1;
  localparam logic [IW-1:0]     ISSUE_END = IW'(LINE_WORDS);
  localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(LINE_WORDS - 1);
  // A line spans LINE_WORDS 2-byte words, so the byte offset is IDXW+1 bits.
  localparam logic [AWIDTH-1:0] LINE_MASK = AWIDTH'(2 * LINE_WORDS - 1);

  // Elaboration-time sanity check on the geometry parameters.
  if (MEM_LAT < 1 || LINE_WORDS < 2 || (LINE_WORDS & (LINE_WORDS - 1)) != 0) begin : g_bad_params
    $error("mem_arbiter: LINE_WORDS must be a power of two >= 2 and MEM_LAT >= 1");
  end

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] addr_q,  addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;

  logic [IW-1:0]     issue_cnt;
  logic [IDXW-1:0]   ret_cnt;

  logic              in_fill;
  logic              in_write;
  logic              issuing;
  logic              last_word;
  logic [AWIDTH-1:0] fill_base;

  assign in_fill   = is_fill(state_q);
  assign in_write  = (state_q == ST_WRITE);
  assign issuing   = in_fill && (issue_cnt < ISSUE_END);
  assign last_word = in_fill && mem_rvalid && (ret_cnt == LAST_IDX);
  assign fill_base = addr_q & ~LINE_MASK;

  // Next-state logic. Address and write data are captured only on the
  // IDLE exit edge, so requester activity during an operation is ignored.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (d_req) begin
          addr_d  = d_addr;
          wdata_d = d_wdata;
          state_d = d_wr ? ST_WRITE : ST_FILL_D;
        end else if (i_req) begin
          addr_d  = i_addr;
          state_d = ST_FILL_I;
        end
      end
      ST_FILL_I, ST_FILL_D: begin
        if (last_word) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        // WRITE is a single cycle.
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Both counters are held at zero outside a fill, so each fill starts at 0.
  mem_arb_counter #(.WIDTH(IW)) u_issue_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_fill),
    .load     (1'b0),
    .load_val ('0),
    .en       (issuing),
    .cnt      (issue_cnt)
  );

  mem_arb_counter #(.WIDTH(IDXW)) u_ret_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (!in_fill),
    .load     (1'b0),
    .load_val ('0),
    .en       (in_fill && mem_rvalid),
    .cnt      (ret_cnt)
  );

  // Outputs decode from the registered state and counters.
  assign i_grant = (state_q == ST_FILL_I);
  assign d_grant = (state_q == ST_FILL_D) || in_write;
  assign busy    = (state_q != ST_IDLE);

  assign mem_en    = issuing || in_write;
  assign mem_wr    = in_write;
  assign mem_wdata = in_write ? wdata_q : '0;

  always_comb begin
    mem_addr = '0;
    if (in_write) begin
      mem_addr = addr_q & ~AWIDTH'(1);
    end else if (issuing) begin
      mem_addr = fill_base + AWIDTH'({issue_cnt, 1'b0});
    end
  end

  // Returns outside a fill are dropped; data is zeroed when not valid.
  assign fill_valid = in_fill && mem_rvalid;
  assign fill_data  = fill_valid ? mem_rdata : '0;
  assign fill_idx   = ret_cnt;

  assign i_done = last_word && (state_q == ST_FILL_I);
  assign d_done = (last_word && (state_q == ST_FILL_D)) || in_write;

endmodule
